// File: rtl/river_pkg.sv
// Shared encodings for the river-crossing game controller: move selects,
// FSM states and bank constants.
package river_pkg;

    localparam logic [1:0] MV_ALONE   = 2'b00;
    localparam logic [1:0] MV_CABBAGE = 2'b01;
    localparam logic [1:0] MV_GOAT    = 2'b10;
    localparam logic [1:0] MV_WOLF    = 2'b11;

    localparam logic START_BANK = 1'b0;
    localparam logic FAR_BANK   = 1'b1;

    typedef enum logic [1:0] {
        PLAY  = 2'b00,
        CHECK = 2'b01,
        WIN   = 2'b10,
        LOSE  = 2'b11
    } game_state_e;

    // Position vector is {F,C,G,W}; cabbage/goat/wolf sit at bits 2/1/0.
    function automatic logic [1:0] item_bit(input logic [1:0] sel);
        return 2'd3 - sel;
    endfunction

endpackage

// File: rtl/river_crossing_ctrl_if.sv
// Game-side bundle between the player, the controller and the downstream
// safety checker.
interface river_crossing_ctrl_if #(
    parameter int MOVE_W = 5
);
    // Handshake: a move is taken on a rising clk edge where move_valid=1 and
    // ready=1; while ready=0 move_valid is ignored and need not be held.
    logic              move_valid;
    logic [1:0]        move_sel;
    logic              alarm_in;
    logic              F;
    logic              C;
    logic              G;
    logic              W;
    logic              ready;
    logic              illegal;
    logic              won;
    logic              lost;
    logic [MOVE_W-1:0] move_count;

    modport slave (
        input  move_valid, move_sel, alarm_in,
        output F, C, G, W, ready, illegal, won, lost, move_count
    );

    modport master (
        output move_valid, move_sel, alarm_in,
        input  F, C, G, W, ready, illegal, won, lost, move_count
    );

endinterface

// File: rtl/river_move_legal.sv
// Combinational move rule: the farmer may cross alone, or with one item that
// is on his own bank. Produces the legal flag and the post-crossing positions.
module river_move_legal
    import river_pkg::*;
(
    input  logic [3:0] pos,
    input  logic [1:0] move_sel,
    output logic       legal,
    output logic [3:0] pos_next
);

    logic [1:0] idx;

    always_comb begin
        idx         = item_bit(move_sel);
        legal       = 1'b1;
        pos_next    = pos;
        pos_next[3] = ~pos[3];
        if (move_sel != MV_ALONE) begin
            legal         = (pos[idx] == pos[3]);
            pos_next[idx] = ~pos[idx];
        end
    end

endmodule

// File: rtl/river_crossing_ctrl.sv
// River-crossing game controller: applies one crossing per accepted move,
// checks the external alarm one cycle later, and tracks win/loss/move count.
module river_crossing_ctrl
    import river_pkg::*;
#(
    parameter int MOVE_W     = 5,
    parameter int MOVE_LIMIT = 15
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  restart,
    river_crossing_ctrl_if.slave  bus,
    output game_state_e           dbg_state
);

    logic [3:0]        pos_q;
    logic [MOVE_W-1:0] count_q;
    game_state_e       state_q;
    logic              ready_q;
    logic              illegal_q;
    logic              won_q;
    logic              lost_q;

    logic              legal;
    logic [3:0]        pos_next;

    river_move_legal u_move_legal (
        .pos      (pos_q),
        .move_sel (bus.move_sel),
        .legal    (legal),
        .pos_next (pos_next)
    );

    // restart behaves exactly like reset so nothing pending survives it.
    always_ff @(posedge clk) begin
        if (!resetn || restart) begin
            pos_q     <= {4{START_BANK}};
            count_q   <= '0;
            state_q   <= PLAY;
            ready_q   <= 1'b1;
            illegal_q <= 1'b0;
            won_q     <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            case (state_q)
                PLAY: begin
                    if (bus.move_valid) begin
                        if (legal) begin
                            pos_q   <= pos_next;
                            count_q <= count_q + 1'b1;
                            state_q <= CHECK;
                            ready_q <= 1'b0;
                        end else begin
                            illegal_q <= 1'b1;
                        end
                    end
                end
                // alarm_in already reflects the positions written on entry.
                CHECK: begin
                    if (bus.alarm_in) begin
                        state_q <= LOSE;
                        lost_q  <= 1'b1;
                    end else if (pos_q == {4{FAR_BANK}}) begin
                        state_q <= WIN;
                        won_q   <= 1'b1;
                    end else if (count_q == MOVE_W'(MOVE_LIMIT)) begin
                        state_q <= LOSE;
                        lost_q  <= 1'b1;
                    end else begin
                        state_q <= PLAY;
                        ready_q <= 1'b1;
                    end
                end
                WIN, LOSE: begin
                    state_q <= state_q;
                end
                default: begin
                    state_q <= PLAY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.F          = pos_q[3];
    assign bus.C          = pos_q[2];
    assign bus.G          = pos_q[1];
    assign bus.W          = pos_q[0];
    assign bus.ready      = ready_q;
    assign bus.illegal    = illegal_q;
    assign bus.won        = won_q;
    assign bus.lost       = lost_q;
    assign bus.move_count = count_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_river_crossing_ctrl.sv
// Directed bench for river_crossing_ctrl: default-limit instance for game play
// and a MOVE_LIMIT=8 instance for the forced-loss case.
module tb_river_crossing_ctrl;
    import river_pkg::*;

    logic clk;
    logic resetn;
    logic restart;
    logic restart8;
    int   checks;
    int   failures;

    game_state_e dbg_state;
    game_state_e dbg_state8;

    river_crossing_ctrl_if #(.MOVE_W(5)) bus ();
    river_crossing_ctrl_if #(.MOVE_W(5)) bus8 ();

    river_crossing_ctrl #(.MOVE_W(5), .MOVE_LIMIT(15)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .restart   (restart),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    river_crossing_ctrl #(.MOVE_W(5), .MOVE_LIMIT(8)) dut8 (
        .clk       (clk),
        .resetn    (resetn),
        .restart   (restart8),
        .bus       (bus8),
        .dbg_state (dbg_state8)
    );

    // Downstream checker: goat left with cabbage or wolf without the farmer.
    function automatic logic alarm_of(input logic [3:0] p);
        return ((p[1] == p[2]) && (p[3] != p[1])) || ((p[1] == p[0]) && (p[3] != p[1]));
    endfunction

    assign bus.alarm_in  = alarm_of({bus.F, bus.C, bus.G, bus.W});
    assign bus8.alarm_in = alarm_of({bus8.F, bus8.C, bus8.G, bus8.W});

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] pos();
        return {bus.F, bus.C, bus.G, bus.W};
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_pos"}, 32'(pos()), 32'h0);
        check({tag, "_count"}, 32'(bus.move_count), 32'd0);
        check({tag, "_ready"}, 32'(bus.ready), 32'd1);
        check({tag, "_illegal"}, 32'(bus.illegal), 32'd0);
        check({tag, "_won"}, 32'(bus.won), 32'd0);
        check({tag, "_lost"}, 32'(bus.lost), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(PLAY));
    endtask

    // Present one move for a single edge, then check the post-move positions.
    task automatic do_move(input logic [1:0] sel, input logic [3:0] exp_pos,
                           input int exp_cnt, input string tag);
        bus.move_valid = 1'b1;
        bus.move_sel   = sel;
        step();
        bus.move_valid = 1'b0;
        check({tag, "_pos"}, 32'(pos()), 32'(exp_pos));
        check({tag, "_count"}, 32'(bus.move_count), 32'(exp_cnt));
        check({tag, "_ready_check"}, 32'(bus.ready), 32'd0);
        step();
    endtask

    logic [3:0] classic_pos [7];
    logic [1:0] classic_sel [7];

    initial begin
        checks         = 0;
        failures       = 0;
        resetn         = 1'b0;
        restart        = 1'b0;
        restart8       = 1'b0;
        bus.move_valid = 1'b0;
        bus.move_sel   = MV_ALONE;
        bus8.move_valid = 1'b0;
        bus8.move_sel   = MV_ALONE;
        classic_sel = '{MV_GOAT, MV_ALONE, MV_WOLF, MV_GOAT, MV_CABBAGE, MV_ALONE, MV_GOAT};
        classic_pos = '{4'b1010, 4'b0010, 4'b1011, 4'b0001, 4'b1101, 4'b0101, 4'b1111};
        step();
        step();
        check_reset("reset");
        resetn = 1'b1;
        step();

        // Classic solution
        for (int i = 0; i < 7; i++) begin
            do_move(classic_sel[i], classic_pos[i], i + 1, $sformatf("classic%0d", i));
            if (i < 6) begin
                check($sformatf("classic%0d_ready", i), 32'(bus.ready), 32'd1);
                check($sformatf("classic%0d_won", i), 32'(bus.won), 32'd0);
            end
        end
        check("classic_won", 32'(bus.won), 32'd1);
        check("classic_lost", 32'(bus.lost), 32'd0);
        check("classic_ready", 32'(bus.ready), 32'd0);
        check("classic_count", 32'(bus.move_count), 32'd7);
        check("classic_state", 32'(dbg_state), 32'(WIN));

        restart = 1'b1;
        step();
        restart = 1'b0;
        check_reset("restart_win");

        // Unsafe first move: farmer alone leaves goat with both
        do_move(MV_ALONE, 4'b1000, 1, "unsafe");
        check("unsafe_lost", 32'(bus.lost), 32'd1);
        check("unsafe_won", 32'(bus.won), 32'd0);
        check("unsafe_ready", 32'(bus.ready), 32'd0);
        bus.move_valid = 1'b1;
        bus.move_sel   = MV_GOAT;
        step();
        step();
        step();
        bus.move_valid = 1'b0;
        check("unsafe_hold_count", 32'(bus.move_count), 32'd1);
        check("unsafe_hold_pos", 32'(pos()), 32'h8);
        check("unsafe_hold_lost", 32'(bus.lost), 32'd1);

        restart = 1'b1;
        step();
        restart = 1'b0;
        check_reset("restart_lose");

        // Illegal request: cabbage on the far side of the farmer
        do_move(MV_GOAT, 4'b1010, 1, "ill_setup");
        check("ill_setup_ready", 32'(bus.ready), 32'd1);
        bus.move_valid = 1'b1;
        bus.move_sel   = MV_CABBAGE;
        step();
        bus.move_valid = 1'b0;
        check("ill_pulse", 32'(bus.illegal), 32'd1);
        check("ill_pos", 32'(pos()), 32'hA);
        check("ill_count", 32'(bus.move_count), 32'd1);
        check("ill_ready", 32'(bus.ready), 32'd1);
        step();
        check("ill_clear", 32'(bus.illegal), 32'd0);

        // Restart mid-game together with a move request
        do_move(MV_ALONE, 4'b0010, 2, "mid2");
        do_move(MV_WOLF, 4'b1011, 3, "mid3");
        check("mid3_ready", 32'(bus.ready), 32'd1);
        restart        = 1'b1;
        bus.move_valid = 1'b1;
        bus.move_sel   = MV_GOAT;
        step();
        restart        = 1'b0;
        bus.move_valid = 1'b0;
        check_reset("restart_mid");

        // Continuous move_valid from reset: one crossing every two cycles
        resetn         = 1'b0;
        bus.move_valid = 1'b1;
        bus.move_sel   = MV_GOAT;
        step();
        check_reset("cont_reset");
        resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("cont%0d_pos", k), 32'(pos()), (k % 2 == 0) ? 32'hA : 32'h0);
            check($sformatf("cont%0d_count", k), 32'(bus.move_count), 32'(k + 1));
            check($sformatf("cont%0d_ready_lo", k), 32'(bus.ready), 32'd0);
            step();
            check($sformatf("cont%0d_count_hold", k), 32'(bus.move_count), 32'(k + 1));
            check($sformatf("cont%0d_ready_hi", k), 32'(bus.ready), 32'd1);
        end
        bus.move_valid = 1'b0;

        // Move limit on the MOVE_LIMIT=8 instance
        for (int i = 0; i < 8; i++) begin
            bus8.move_valid = 1'b1;
            bus8.move_sel   = MV_GOAT;
            step();
            bus8.move_valid = 1'b0;
            check($sformatf("lim%0d_count", i), 32'(bus8.move_count), 32'(i + 1));
            step();
            if (i < 7) begin
                check($sformatf("lim%0d_ready", i), 32'(bus8.ready), 32'd1);
                check($sformatf("lim%0d_lost", i), 32'(bus8.lost), 32'd0);
            end
        end
        check("lim_lost", 32'(bus8.lost), 32'd1);
        check("lim_won", 32'(bus8.won), 32'd0);
        check("lim_ready", 32'(bus8.ready), 32'd0);
        check("lim_pos", 32'({bus8.F, bus8.C, bus8.G, bus8.W}), 32'h0);
        bus8.move_valid = 1'b1;
        step();
        step();
        bus8.move_valid = 1'b0;
        check("lim_no_wrap", 32'(bus8.move_count), 32'd8);
        check("lim_state", 32'(dbg_state8), 32'(LOSE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
